// File: rtl/systolic_output_drain.sv
// Receive end of the systolic array: deskews row-skewed result lanes into aligned vectors,
// buffers them in a FIFO and drains them over valid/ready. Optional macro: DRAIN_RELU_EN.
module systolic_output_drain #(
  parameter int ARRAY_M      = 8,
  parameter int PE_OUT_WIDTH = 32,
  parameter int LATENCY      = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [CNT_WIDTH-1:0]            num_vectors,
  input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] result_data_set_in,
  output logic [ARRAY_M*PE_OUT_WIDTH-1:0] out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            done,
  output logic                            overflow
);
  localparam int VW       = ARRAY_M * PE_OUT_WIDTH;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int WAIT_CYC = LATENCY + ARRAY_M - 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] WAIT_LAST = CNT_WIDTH'(WAIT_CYC - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN, S_DONE} state_t;

  function automatic logic [VW-1:0] relu_vec(input logic [VW-1:0] v);
    logic [VW-1:0] r;
    r = v;
`ifdef DRAIN_RELU_EN
    for (int m = 0; m < ARRAY_M; m++)
      if (v[m*PE_OUT_WIDTH + PE_OUT_WIDTH - 1]) r[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] = '0;
`endif
    return r;
  endfunction

  logic signed [PE_OUT_WIDTH-1:0] lane_in [ARRAY_M];
  logic signed [PE_OUT_WIDTH-1:0] aligned [ARRAY_M];
  logic [VW-1:0] aligned_vec;

  // Skew stage: lane m is delayed ARRAY_M-1-m cycles so all lanes of a vector line up.
  for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
    assign lane_in[m] = result_data_set_in[m*PE_OUT_WIDTH +: PE_OUT_WIDTH];
  end

  for (genvar m = 0; m < ARRAY_M - 1; m++) begin : g_skew
    localparam int D = ARRAY_M - 1 - m;
    logic signed [PE_OUT_WIDTH-1:0] skew_q [D];
    logic signed [PE_OUT_WIDTH-1:0] skew_d [D];
    always_comb begin
      skew_d[0] = lane_in[m];
      for (int s = 1; s < D; s++) skew_d[s] = skew_q[s-1];
    end
    always_ff @(posedge clk) skew_q <= skew_d;
    assign aligned[m] = skew_q[D-1];
  end
  assign aligned[ARRAY_M-1] = lane_in[ARRAY_M-1];

  always_comb begin
    aligned_vec = '0;
    for (int m = 0; m < ARRAY_M; m++)
      aligned_vec[m*PE_OUT_WIDTH +: PE_OUT_WIDTH] = aligned[m];
  end

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] k_q, k_d, cnt_q, cnt_d;
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 overflow_q, overflow_d, done_q, done_d, busy_q, busy_d;
  logic                 push, pop, full, wr_en, vec_last;
  logic [VW:0]          mem_q [FIFO_DEPTH];

  // FIFO stage: each entry holds {last tag, aligned vector}.
  always_comb begin
    pop      = out_valid && out_ready;
    push     = (state_q == S_CAPTURE);
    full     = (count_q == (AW+1)'(FIFO_DEPTH));
    wr_en    = push && (!full || pop);
    vec_last = push && (cnt_q == k_q - CNT_ONE);
    wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_ptr_q] <= {vec_last, relu_vec(aligned_vec)};

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q][VW-1:0] : '0;
  assign out_last  = out_valid & mem_q[rd_ptr_q][VW];

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    overflow_d = overflow_q | (push && full && !pop);
    unique case (state_q)
      S_IDLE: if (start) begin
        k_d        = num_vectors;
        cnt_d      = '0;
        overflow_d = 1'b0;
        if (num_vectors == '0) state_d = S_DONE;
        else if (WAIT_CYC == 0) state_d = S_CAPTURE;
        else                    state_d = S_WAIT;
      end
      S_WAIT: if (cnt_q == WAIT_LAST) begin
        cnt_d   = '0;
        state_d = S_CAPTURE;
      end else cnt_d = cnt_q + CNT_ONE;
      S_CAPTURE: if (cnt_q == k_q - CNT_ONE) begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end else cnt_d = cnt_q + CNT_ONE;
      // Leave once the FIFO will be empty after this edge, counting a pop happening now.
      S_DRAIN: if (count_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    done_d = (state_q == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_systolic_output_drain.sv
// Scoreboard bench for systolic_output_drain: models the skewed array, the FIFO occupancy,
// drops and done timing; expected vectors are queued at push time and compared on handshake.
module tb_systolic_output_drain;
  localparam int M = 4, W = 32, LAT = 3, DEPTH = 4, CW = 16;
  localparam int VW = M * W;
  typedef logic [VW:0] val_t;

  logic clk = 1'b0;
  logic reset, start, out_ready, out_valid, out_last, busy, done, overflow;
  logic [CW-1:0] num_vectors;
  logic [VW-1:0] result_data_set_in, out_data;

  int   checks = 0, errors = 0;
  val_t sb_q[$];
  logic ovf_exp;

  always #5 clk = ~clk;

  systolic_output_drain #(
    .ARRAY_M(M), .PE_OUT_WIDTH(W), .LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
    .result_data_set_in(result_data_set_in), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy), .done(done), .overflow(overflow)
  );

  task automatic check_eq(input string tag, input val_t got, input val_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] lane_val(input int pat, input int k, input int m);
    if (pat == 0) return W'(16 * k + m);
    case (m)
      0:       return 32'hFFFF_FFF6;
      1:       return 32'd5;
      2:       return 32'h8000_0000;
      default: return 32'h7FFF_FFFF;
    endcase
  endfunction

  function automatic logic [W-1:0] exp_lane(input logic [W-1:0] v);
`ifdef DRAIN_RELU_EN
    if (v[W-1]) return '0;
`endif
    return v;
  endfunction

  function automatic logic [VW-1:0] exp_vec(input int pat, input int k);
    logic [VW-1:0] v;
    for (int m = 0; m < M; m++) v[m*W +: W] = exp_lane(lane_val(pat, k, m));
    return v;
  endfunction

  // Lane m carries vector k during cycle LAT+k+m; other cycles carry recognisable junk.
  task automatic drive_lanes(input int r, input int k, input int pat);
    for (int m = 0; m < M; m++) begin
      int kk;
      kk = r - LAT - m;
      if (kk >= 0 && kk < k) result_data_set_in[m*W +: W] = lane_val(pat, kk, m);
      else result_data_set_in[m*W +: W] = 32'hA5A5_0000 + W'(r * 16 + m);
    end
  endtask

  task automatic run_tile(input int k, input int pat, input int rdy_from,
                          input int restart_at, input int reset_at);
    int   done_exp, last_push_cyc, done_seen, kk;
    bit   pop, hold_v;
    logic [VW-1:0] held;
    @(negedge clk);
    check_eq("ovf_idle", val_t'(overflow), val_t'(ovf_exp));
    start = 1'b1;
    num_vectors = CW'(k);
    out_ready = (rdy_from <= -1);
    drive_lanes(-1, k, pat);
    sb_q.delete();
    ovf_exp = 1'b0;
    done_exp = (k == 0) ? 1 : -1;
    last_push_cyc = LAT + M - 1 + k - 1;
    done_seen = 0;
    hold_v = 1'b0;
    held = '0;
    for (int r = 0; r < 80; r++) begin
      @(negedge clk);
      start = (r == restart_at);
      num_vectors = (r == restart_at) ? CW'(k + 4) : CW'(k);
      if (r == reset_at - 1) reset = 1'b0;
      out_ready = (r >= rdy_from);
      drive_lanes(r, k, pat);
      if (reset_at >= 0 && r == reset_at) begin
        reset = 1'b1;
        check_eq("rst_ctl", val_t'({out_valid, out_last, busy, done, overflow}), val_t'(0));
        check_eq("rst_data", val_t'(out_data), val_t'(0));
        sb_q.delete();
        ovf_exp = 1'b0;
        break;
      end
      check_eq("valid", val_t'(out_valid), val_t'(sb_q.size() != 0));
      check_eq("ovf", val_t'(overflow), val_t'(ovf_exp));
      check_eq("done", val_t'(done), val_t'(r == done_exp));
      if (r == 0) check_eq("busy0", val_t'(busy), val_t'(1));
      if (done) done_seen++;
      if (hold_v && out_valid) check_eq("hold", val_t'(out_data), val_t'(held));
      hold_v = out_valid && !out_ready;
      held = out_data;
      if (out_valid && sb_q.size() != 0) begin
        check_eq("last", val_t'(out_last), val_t'(sb_q[0][VW]));
        check_eq("data", val_t'(out_data), val_t'(sb_q[0][VW-1:0]));
      end
      pop = (sb_q.size() != 0) && out_ready;
      if (pop) void'(sb_q.pop_front());
      kk = r - (LAT + M - 1);
      if (kk >= 0 && kk < k) begin
        if (sb_q.size() == DEPTH) ovf_exp = 1'b1;
        else sb_q.push_back({kk == k - 1, exp_vec(pat, kk)});
      end
      if (done_exp < 0 && k > 0 && r > last_push_cyc && sb_q.size() == 0) done_exp = r + 2;
      if (done_exp >= 0 && r >= done_exp + 1) begin
        check_eq("busy_end", val_t'(busy), val_t'(0));
        break;
      end
    end
    if (reset_at < 0) begin
      check_eq("done_once", val_t'(done_seen), val_t'(1));
      check_eq("sb_empty", val_t'(sb_q.size()), val_t'(0));
    end
  endtask

  initial begin
    reset = 1'b0;
    start = 1'b0;
    num_vectors = '0;
    out_ready = 1'b0;
    result_data_set_in = '0;
    ovf_exp = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_ctl", val_t'({out_valid, out_last, busy, done, overflow}), val_t'(0));
    check_eq("reset_data", val_t'(out_data), val_t'(0));
    reset = 1'b1;

    run_tile(2, 0, 0, -1, -1);   // basic deskew
    run_tile(4, 0, 12, -1, -1);  // backpressure
    run_tile(6, 0, 12, -1, -1);  // overflow: vectors 4 and 5 dropped
    run_tile(0, 0, 0, -1, -1);   // zero length; start also clears overflow
    run_tile(3, 0, 0, 2, -1);    // second start during WAIT ignored
    run_tile(4, 0, 0, -1, 8);    // reset mid-CAPTURE
    repeat (5) begin
      @(negedge clk);
      check_eq("rst_quiet", val_t'({out_valid, busy, done}), val_t'(0));
    end
    run_tile(1, 0, 0, -1, -1);   // fresh tile after reset
    run_tile(1, 1, 0, -1, -1);   // negative and extreme lane values

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
